// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Optional early-out for multiplies when the remaining multiplier bits are zero: `define MUL_DIV_EARLY_OUT_EN.
module mul_div_unit #(
   parameter int DATA_SIZE = 32,
   parameter int CNT_SIZE  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   input  logic                 hi_we,
   input  logic                 lo_we,
   input  logic [DATA_SIZE-1:0] i_data,
   output logic                 busy,
   output logic                 done,
   output logic [DATA_SIZE-1:0] hi,
   output logic [DATA_SIZE-1:0] lo
);
   localparam int W = DATA_SIZE;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [CNT_SIZE-1:0] LAST = CNT_SIZE'(DATA_SIZE);

   logic [1:0]          state;
   logic [CNT_SIZE-1:0] cnt;
   logic                is_div;
   logic                neg_lo;
   logic                neg_hi;
   logic                div0;
   logic [W-1:0]        a_lat;
   logic [2*W-1:0]      m;
   logic [W-1:0]        y;
   logic [2*W-1:0]      acc;

   logic           sgn;
   logic [W-1:0]   abs_a;
   logic [W-1:0]   abs_b;
   logic [W:0]     diff;
   logic [2*W-1:0] acc_nxt;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [W-1:0]   fin_hi;
   logic [W-1:0]   fin_lo;
   logic           early;

   assign sgn   = ~op[0];
   assign abs_a = (sgn && a[W-1]) ? -a : a;
   assign abs_b = (sgn && b[W-1]) ? -b : b;

   // Divide keeps {remainder, dividend/quotient} in acc; the remainder needs one extra bit after the shift.
   always_comb begin
      diff    = acc[2*W-1:W-1] - {1'b0, y};
      acc_nxt = acc;
      if (is_div) begin
         if (diff[W])
            acc_nxt = {acc[2*W-2:0], 1'b0};
         else
            acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
      end else if (y[0]) begin
         acc_nxt = acc + m;
      end
   end

   assign prod   = neg_lo ? -acc : acc;
   assign quo    = neg_lo ? -acc[W-1:0] : acc[W-1:0];
   assign rem    = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
   assign fin_lo = div0 ? {W{1'b1}} : (is_div ? quo : prod[W-1:0]);
   assign fin_hi = div0 ? a_lat : (is_div ? rem : prod[2*W-1:W]);

`ifdef MUL_DIV_EARLY_OUT_EN
   assign early = !is_div && ((y == '0) || (m == '0));
`else
   assign early = 1'b0;
`endif

   assign busy = (state == S_CALC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         div0   <= 1'b0;
         a_lat  <= '0;
         m      <= '0;
         y      <= '0;
         acc    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hi_we) hi <= i_data;
               if (lo_we) lo <= i_data;
               if (start) begin
                  state  <= S_CALC;
                  cnt    <= '0;
                  is_div <= op[1];
                  neg_lo <= sgn && (a[W-1] ^ b[W-1]);
                  neg_hi <= sgn && a[W-1];
                  div0   <= op[1] && (b == '0);
                  a_lat  <= a;
                  m      <= {{W{1'b0}}, abs_a};
                  y      <= abs_b;
                  acc    <= op[1] ? {{W{1'b0}}, abs_a} : '0;
               end
            end
            S_CALC: begin
               // Final cycle applies the sign fix-up and commits HI/LO.
               if (cnt == LAST) begin
                  hi    <= fin_hi;
                  lo    <= fin_lo;
                  done  <= 1'b1;
                  state <= S_FIN;
               end else if (early) begin
                  cnt <= LAST;
               end else begin
                  acc <= acc_nxt;
                  m   <= m << 1;
                  if (!is_div) y <= y >> 1;
                  cnt <= cnt + 1'b1;
               end
            end
            S_FIN: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors queued at issue, checked when done pulses.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] i_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   int   cyc    = 0;

   mul_div_unit #(.DATA_SIZE(32), .CNT_SIZE(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .i_data(i_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
         end else begin
            e = sb.pop_front();
            check("hi", {32'b0, hi}, {32'b0, e.hi});
            check("lo", {32'b0, lo}, {32'b0, e.lo});
            check("busy_in_fin", {63'b0, busy}, 64'd0);
`ifndef MUL_DIV_EARLY_OUT_EN
            check("latency", 64'(cyc), 64'(e.cyc));
`endif
         end
      end
   end

   task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      e.hi  = eh;
      e.lo  = el;
      e.cyc = cyc + 34;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      push_exp(eh, el);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      check("busy_rise", {63'b0, busy}, 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: got %0d results pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; i_data = '0;
      repeat (2) @(negedge clk);
      check("rst_hi",   {32'b0, hi}, 64'd0);
      check("rst_lo",   {32'b0, lo}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Abort by reset in CALC: no result may land.
      start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", {63'b0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_hi", {32'b0, hi}, 64'd0);
      check("abort_lo", {32'b0, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(n_done), 64'd0);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001); wait_idle();
      issue(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB); wait_idle();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD); wait_idle();
      issue(2'b11, 32'd100,       32'd7,         32'd2,         32'd14);        wait_idle();
      issue(2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF); wait_idle();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000); wait_idle();
      issue(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF); wait_idle();
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000); wait_idle();

      // MTLO/MTHI while idle.
      lo_we = 1'b1; i_data = 32'hCAFE_BABE;
      @(negedge clk);
      lo_we = 1'b0; hi_we = 1'b1; i_data = 32'h0BAD_F00D;
      check("mtlo_idle", {32'b0, lo}, 64'h0000_0000_CAFE_BABE);
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_idle", {32'b0, hi}, 64'h0000_0000_0BAD_F00D);

      // Writes and a second start while busy are ignored.
      d0 = n_done;
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      lo_we = 1'b1; i_data = 32'hDEAD_BEEF;
      start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
      @(negedge clk);
      lo_we = 1'b0; start = 1'b0;
      check("mtlo_busy", {32'b0, lo}, 64'h0000_0000_CAFE_BABE);
      wait_idle();
      repeat (40) @(negedge clk);
      check("one_done", 64'(n_done - d0), 64'd1);

      // Same-cycle start and MTHI: write lands, result overwrites later.
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; hi_we = 1'b1; i_data = 32'h55;
      push_exp(32'd0, 32'd15);
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom;
      check("mthi_with_start", {32'b0, hi}, 64'h55);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the execute stage, directly downstream of the register file.
- Consumes the two register read ports (rs → a, rt → b) and holds the HI/LO architectural registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Multi-cycle; signals busy so the controller stalls issue.
- All state updates on rising edge of clk (register file writes on falling edge, so read data is stable at the rising edge).

Parameters:
- DATA_SIZE, 32, operand/HI/LO width.
- CNT_SIZE, 6, iteration counter width; must hold DATA_SIZE.

Ports:
- clk  input  1  system clock, rising edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  DATA_SIZE  rs operand (register file o_data_j).
- b  input  DATA_SIZE  rt operand (register file o_data_k).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- i_data  input  DATA_SIZE  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a result.
- hi  output  DATA_SIZE  HI register (MFHI source).
- lo  output  DATA_SIZE  LO register (MFLO source).

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
  - Reset mid-operation aborts it; HI/LO do not keep partial results.
- States:
  - IDLE: start=1 latches op, a, b and goes to CALC. busy rises the next cycle.
  - CALC: one iteration per cycle for DATA_SIZE cycles, then goes to FIN.
  - FIN: writes hi/lo, done=1 for one cycle, busy=0, then returns to IDLE.
- Latency: start sampled at edge N → done=1 and new hi/lo visible after edge N+DATA_SIZE+1 (33 cycles for 32-bit).
- busy=1 in CALC only; done=1 in FIN only. A start during FIN or CALC is ignored (busy protocol: controller holds start until busy=0).
- Signed ops (MULT, DIV):
  - Operate on magnitudes; |−2^31| is treated as unsigned 0x80000000.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
- Multiply:
  - Shift-add over the 2×DATA_SIZE product.
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring division, one quotient bit per cycle.
  - lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) → lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency still applies.
  - Result is forced to lo=0xFFFFFFFF, hi=a (as latched), independent of signedness.
- MTHI/MTLO:
  - hi_we writes i_data to hi, lo_we writes i_data to lo, on the rising edge when state=IDLE.
  - Ignored in CALC/FIN; the controller must not issue them while busy.
  - Same-cycle start and hi_we/lo_we in IDLE: the write takes effect, the operation starts, and its result later overwrites both.
- Operands are latched at start; later changes to a/b have no effect on the result.

Optional Feature:
- Macro: MUL_DIV_EARLY_OUT_EN.
- Defined:
  - In CALC, a MULT/MULTU whose remaining multiplier bits are all zero goes to FIN immediately. Minimum latency 2 cycles when b=0 or a=0 (when a=0 the product is 0).
  - Division is unaffected.
  - done/busy semantics are unchanged.
- Undefined: fixed DATA_SIZE+1 cycle latency for all ops.

Test Plan:
- Reset then idle → hi=0, lo=0, busy=0, done=0. Assert rst in CALC cycle 10 → busy=0 immediately, hi/lo remain at pre-op values.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO i_data=0xCAFEBABE while idle → lo=0xCAFEBABE next cycle. Same during busy → lo unchanged. Start pulsed again while busy → ignored, exactly one done pulse.
